// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : mem_port_arbiter_pkg                                     |
// | Description : Shared types for the ibus/dbus memory-port arbiter:      |
// |               FSM states, grant encoding, access size code and the     |
// |               registered downstream request record.                    |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package mem_port_arbiter_pkg;

  localparam int c_ADDR_W = 64;
  localparam int c_DATA_W = 64;
  localparam int c_STRB_W = c_DATA_W / 8;

  // Access size code: log2 of the access size in bytes.
  typedef logic [2:0] msize_t;
  localparam msize_t c_MSIZE_8B = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } arb_grant_e;

  typedef struct packed {
    logic [c_ADDR_W-1:0] addr;
    msize_t              size;
    logic [c_STRB_W-1:0] strobe;
    logic [c_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/arb_starve_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : arb_starve_counter                                       |
// | Description : Saturating counter of consecutive dbus grants taken      |
// |               while ibus was waiting. Clear has priority over         |
// |               increment; o_sat flags that the limit is reached.        |
// | Revision    : 1.0  initial release                                     |
// | Ports       : clk, reset (async, active-high)                          |
// |               i_inc  - count one dbus grant over a waiting ibus        |
// |               i_clr  - return count to zero                            |
// |               o_sat  - count equals STARVE_MAX                         |
// +------------------------------------------------------------------------+
module arb_starve_counter #(
  parameter  int STARVE_MAX = 4,
  localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam logic [CNT_W-1:0] c_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_sat) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign o_sat = (r_count == c_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                         |
// | Description : Shares one single-outstanding memory port between the    |
// |               instruction bus (ibus) and data bus (dbus). dbus has     |
// |               priority; a starvation counter forces an ibus grant      |
// |               after STARVE_MAX consecutive dbus wins.                  |
// | Revision    : 1.0  initial release                                     |
// | Ports       : clk, reset (async, active-high)                          |
// |               ibus : i_valid, i_addr -> i_addr_ok, i_data_ok, i_data   |
// |               dbus : d_valid, d_addr, d_size, d_strobe, d_wdata        |
// |                      -> d_addr_ok, d_data_ok, d_data                   |
// |               mem  : m_valid, m_addr, m_size, m_strobe, m_wdata,       |
// |                      m_ready, m_rvalid, m_rdata                        |
// |               busy : transaction in progress                           |
// +------------------------------------------------------------------------+
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int ADDR_W     = c_ADDR_W,
  parameter  int DATA_W     = c_DATA_W,
  parameter  int STARVE_MAX = 4,
  localparam int STRB_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  // instruction bus
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_data,
  // data bus
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_size,
  input  logic [STRB_W-1:0] d_strobe,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_data,
  // memory port
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [2:0]        m_size,
  output logic [STRB_W-1:0] m_strobe,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  arb_grant_e r_grant;
  mem_req_t   r_req;

  logic w_arb_en;
  logic w_pick_i;
  logic w_starve_sat;
  logic w_starve_inc;
  logic w_starve_clr;

  // ibus wins when dbus is absent or dbus has already won STARVE_MAX times
  // in a row over a waiting ibus.
  assign w_pick_i     = i_valid && (!d_valid || w_starve_sat);
  assign w_starve_inc = w_arb_en && i_valid && !w_pick_i;
  assign w_starve_clr = w_arb_en && (!i_valid || w_pick_i);

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_starve_inc),
    .i_clr (w_starve_clr),
    .o_sat (w_starve_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arb_en    = 1'b0;
    m_valid     = 1'b0;
    i_addr_ok   = 1'b0;
    d_addr_ok   = 1'b0;
    i_data_ok   = 1'b0;
    d_data_ok   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_valid || d_valid) begin
          w_arb_en    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        m_valid = 1'b1;
        if (m_ready) begin
          i_addr_ok   = (r_grant == GNT_I);
          d_addr_ok   = (r_grant == GNT_D);
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (m_rvalid) begin
          i_data_ok   = (r_grant == GNT_I);
          d_data_ok   = (r_grant == GNT_D);
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request fields are latched at arbitration so the requester may drop
  // valid afterwards without disturbing the downstream transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req   <= '0;
      r_grant <= GNT_NONE;
    end else if (w_arb_en) begin
      if (w_pick_i) begin
        r_req.addr   <= i_addr;
        r_req.size   <= c_MSIZE_8B;
        r_req.strobe <= '0;
        r_req.wdata  <= '0;
        r_grant      <= GNT_I;
      end else begin
        r_req.addr   <= d_addr;
        r_req.size   <= d_size;
        r_req.strobe <= d_strobe;
        r_req.wdata  <= d_wdata;
        r_grant      <= GNT_D;
      end
    end else if (r_state == WAIT && m_rvalid) begin
      r_grant <= GNT_NONE;
    end
  end

  assign m_addr   = r_req.addr;
  assign m_size   = r_req.size;
  assign m_strobe = r_req.strobe;
  assign m_wdata  = r_req.wdata;

  assign i_data = i_data_ok ? m_rdata : '0;
  assign d_data = d_data_ok ? m_rdata : '0;
  assign busy   = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                      |
// | Description : Self-checking bench for mem_port_arbiter. A transaction- |
// |               level reference model predicts every output each cycle. |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 64;
  localparam int STRB_W     = 8;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_valid;
  logic [ADDR_W-1:0] i_addr;
  logic              i_addr_ok, i_data_ok;
  logic [DATA_W-1:0] i_data;
  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic [2:0]        d_size;
  logic [STRB_W-1:0] d_strobe;
  logic [DATA_W-1:0] d_wdata;
  logic              d_addr_ok, d_data_ok;
  logic [DATA_W-1:0] d_data;
  logic              m_valid, m_ready;
  logic [ADDR_W-1:0] m_addr;
  logic [2:0]        m_size;
  logic [STRB_W-1:0] m_strobe;
  logic [DATA_W-1:0] m_wdata;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic              busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_addr    (i_addr),
    .i_addr_ok (i_addr_ok),
    .i_data_ok (i_data_ok),
    .i_data    (i_data),
    .d_valid   (d_valid),
    .d_addr    (d_addr),
    .d_size    (d_size),
    .d_strobe  (d_strobe),
    .d_wdata   (d_wdata),
    .d_addr_ok (d_addr_ok),
    .d_data_ok (d_data_ok),
    .d_data    (d_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_addr    (m_addr),
    .m_size    (m_size),
    .m_strobe  (m_strobe),
    .m_wdata   (m_wdata),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction record.
  bit          mdl_act;      // a request has been granted and not yet answered
  bit          mdl_hs;       // downstream has accepted it
  bit          mdl_isi;      // granted side is ibus
  logic [63:0] mdl_addr, mdl_wdata;
  logic [2:0]  mdl_size;
  logic [7:0]  mdl_strb;
  int          mdl_starve;   // dbus wins in a row while ibus waited

  bit last_iaok, last_daok;  // model-predicted accept pulses of the last cycle
  int grants[$];             // observed grant order: 1 = ibus, 0 = dbus

  // Inputs are set at posedge+1; outputs are checked at the following negedge
  // and the model then advances by one clock.
  task automatic tick();
    bit e_mv, e_iao, e_dao, e_ido, e_ddo;
    @(negedge clk);
    if (reset) begin
      mdl_act = 0; mdl_hs = 0; mdl_starve = 0;
      e_iao = 0; e_dao = 0;
      check_val("rst_m_valid", m_valid, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_oks", {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, 0);
      check_val("rst_idata", i_data, 0);
      check_val("rst_ddata", d_data, 0);
    end else begin
      e_mv  = mdl_act && !mdl_hs;
      e_iao = e_mv && m_ready && mdl_isi;
      e_dao = e_mv && m_ready && !mdl_isi;
      e_ido = mdl_act && mdl_hs && m_rvalid && mdl_isi;
      e_ddo = mdl_act && mdl_hs && m_rvalid && !mdl_isi;
      check_val("m_valid", m_valid, e_mv);
      check_val("busy", busy, mdl_act);
      check_val("i_addr_ok", i_addr_ok, e_iao);
      check_val("d_addr_ok", d_addr_ok, e_dao);
      check_val("i_data_ok", i_data_ok, e_ido);
      check_val("d_data_ok", d_data_ok, e_ddo);
      check_val("i_data", i_data, e_ido ? m_rdata : 64'd0);
      check_val("d_data", d_data, e_ddo ? m_rdata : 64'd0);
      if (e_mv) begin
        check_val("m_addr", m_addr, mdl_addr);
        check_val("m_size", m_size, mdl_size);
        check_val("m_strobe", m_strobe, mdl_strb);
        check_val("m_wdata", m_wdata, mdl_wdata);
      end
      if (!mdl_act) begin
        if (i_valid || d_valid) begin
          mdl_isi = i_valid && (!d_valid || mdl_starve == STARVE_MAX);
          if (mdl_isi) begin
            mdl_addr = i_addr; mdl_size = 3'd3; mdl_strb = 8'd0; mdl_wdata = 64'd0;
            mdl_starve = 0;
          end else begin
            mdl_addr = d_addr; mdl_size = d_size; mdl_strb = d_strobe; mdl_wdata = d_wdata;
            mdl_starve = i_valid ? ((mdl_starve < STARVE_MAX) ? mdl_starve + 1 : STARVE_MAX) : 0;
          end
          mdl_act = 1;
          mdl_hs  = 0;
        end
      end else if (!mdl_hs) begin
        if (m_ready) mdl_hs = 1;
      end else if (m_rvalid) begin
        mdl_act = 0;
      end
    end
    last_iaok = e_iao;
    last_daok = e_dao;
    if (i_addr_ok) grants.push_back(1);
    else if (d_addr_ok) grants.push_back(0);
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with fixed downstream delays. With hold set the
  // accepted requester immediately presents a new request instead of dropping.
  task automatic do_txn(input int rdy_dly, input int rsp_dly, input logic [63:0] rdata,
                        input bit hold);
    m_ready  = 0;
    m_rvalid = 0;
    tick();
    repeat (rdy_dly) tick();
    m_ready = 1;
    tick();
    m_ready = 0;
    if (last_iaok) begin
      if (hold) i_addr = i_addr + 64'd4; else i_valid = 0;
    end
    if (last_daok) begin
      if (hold) d_addr = d_addr + 64'd8; else d_valid = 0;
    end
    repeat (rsp_dly - 1) tick();
    m_rvalid = 1;
    m_rdata  = rdata;
    tick();
    m_rvalid = 0;
  endtask

  bit i_pend, d_pend;

  initial begin
    reset = 1;
    i_valid = 0; i_addr = '0;
    d_valid = 0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
    m_ready = 0; m_rvalid = 0; m_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_m_addr", m_addr, 0);
    check_val("rst_m_fields", {m_size, m_strobe, m_wdata}, 0);
    tick();
    reset = 0;
    tick();

    // ibus fetch alone
    i_valid = 1; i_addr = 64'h8000_0000;
    do_txn(0, 2, 64'h13, 0);
    check_val("t1_grant", grants[grants.size()-1], 1);

    // simultaneous: dbus store first, then ibus
    i_valid = 1; i_addr = 64'h8000_0040;
    d_valid = 1; d_addr = 64'h8000_1000; d_size = 3'd3; d_strobe = 8'hFF; d_wdata = 64'hDEAD;
    do_txn(0, 1, 64'h0, 0);
    check_val("t2_first_d", grants[grants.size()-1], 0);
    do_txn(1, 1, 64'h77, 0);
    check_val("t2_then_i", grants[grants.size()-1], 1);

    // starvation: both held, four dbus wins then ibus, then dbus again
    grants.delete();
    i_valid = 1; i_addr = 64'h8000_2000;
    d_valid = 1; d_addr = 64'h9000_0000; d_size = 3'd2; d_strobe = 8'h0F; d_wdata = 64'h1234;
    for (int k = 0; k < 6; k++) do_txn(0, 1, 64'(k + 100), 1);
    check_val("t3_count", grants.size(), 6);
    for (int k = 0; k < 6; k++) check_val($sformatf("t3_gnt%0d", k), grants[k], (k == 4) ? 1 : 0);
    i_valid = 0; d_valid = 0;
    tick();

    // downstream stalls 5 cycles in ISSUE
    d_valid = 1; d_addr = 64'hA000_0008; d_size = 3'd0; d_strobe = 8'h00; d_wdata = 64'h55;
    do_txn(5, 3, 64'hCAFE, 0);

    // spurious response while idle
    m_rvalid = 1; m_rdata = 64'hBAD;
    tick();
    tick();
    m_rvalid = 0;
    tick();

    // reset asserted while waiting for a response
    i_valid = 1; i_addr = 64'h8000_3000;
    tick();
    m_ready = 1;
    tick();
    m_ready = 0; i_valid = 0;
    tick();
    m_rvalid = 1; m_rdata = 64'h5A5A;
    reset = 1;
    #1;
    check_val("t6_async_busy", busy, 0);
    check_val("t6_async_oks", {m_valid, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, 0);
    check_val("t6_async_idata", i_data, 0);
    check_val("t6_async_maddr", m_addr, 0);
    tick();
    reset = 0; m_rvalid = 0;
    tick();
    d_valid = 1; d_addr = 64'hB000_0010; d_size = 3'd1; d_strobe = 8'h03; d_wdata = 64'hBEEF;
    do_txn(1, 2, 64'h600D, 0);
    check_val("t6_fresh_grant", grants[grants.size()-1], 0);

    // randomized traffic
    i_pend = 0; d_pend = 0;
    for (int c = 0; c < 2000; c++) begin
      if (i_pend && last_iaok) i_pend = 0;
      if (d_pend && last_daok) d_pend = 0;
      if (i_pend && mdl_act && !mdl_hs && mdl_isi && $urandom_range(15) == 0) i_pend = 0;
      if (d_pend && mdl_act && !mdl_hs && !mdl_isi && $urandom_range(15) == 0) d_pend = 0;
      if (!i_pend && !(mdl_act && mdl_isi) && $urandom_range(3) == 0) begin
        i_pend = 1;
        i_addr = {$urandom, $urandom};
      end
      if (!d_pend && !(mdl_act && !mdl_isi) && $urandom_range(2) == 0) begin
        d_pend   = 1;
        d_addr   = {$urandom, $urandom};
        d_size   = 3'($urandom_range(3));
        d_strobe = ($urandom_range(1) == 0) ? 8'd0 : 8'($urandom);
        d_wdata  = {$urandom, $urandom};
      end
      i_valid  = i_pend;
      d_valid  = d_pend;
      m_ready  = 1'($urandom_range(1));
      m_rdata  = {$urandom, $urandom};
      if (mdl_act && mdl_hs) m_rvalid = ($urandom_range(2) == 0);
      else if (!mdl_act)     m_rvalid = ($urandom_range(7) == 0);
      else                   m_rvalid = 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
